// File: rtl/load_store_unit.sv
// Load/store unit: sequences one memory access per LOAD/STORE over a req/ack bus,
// with lane steering, sign/zero extension and an ack timeout. Define MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module load_store_unit #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addrLo;
    logic        r_isLoad;
    logic        r_pendErr;
    logic        r_respDone;
    logic [31:0] r_rdData;
    logic        r_done;
    logic        r_busy;
    logic        r_err;
    logic        r_memReq;
    logic        r_memWe;
    logic [31:0] r_memAddr;
    logic [31:0] r_memWdata;
    logic [3:0]  r_memBe;

    logic        w_isLoad;
    logic        w_isStore;
    logic        w_accept;
    logic        w_sizeOk;
    logic        w_misalign;
    logic        w_fault;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadVal;
    logic [7:0]  w_cntNext;

    assign w_isLoad  = (opcode == OP_LOAD);
    assign w_isStore = (opcode == OP_STORE);
    assign w_accept  = start && (r_state == S_IDLE) && (w_isLoad || w_isStore);
    assign w_cntNext = r_cnt + 8'd1;

    // Unsigned sizes exist only for loads; every other encoding is a fault.
    always_comb begin
        w_sizeOk = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_sizeOk = 1'b1;
            3'b100, 3'b101:         w_sizeOk = w_isLoad;
            default:                w_sizeOk = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = !w_sizeOk || w_misalign;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata;
            end
        endcase
    end

    // Load lane extraction uses the address captured at acceptance.
    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_addrLo)
            2'b00: w_byte = mem_rdata[7:0];
            2'b01: w_byte = mem_rdata[15:8];
            2'b10: w_byte = mem_rdata[23:16];
            2'b11: w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_addrLo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_loadVal = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_loadVal = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadVal = {24'd0, w_byte};
            3'b101:  w_loadVal = {16'd0, w_half};
            default: w_loadVal = mem_rdata;
        endcase
    end

    // RESP lasts two cycles on bus completions (mem_req low, then done) but one on faults.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_funct3   <= 3'd0;
            r_addrLo   <= 2'd0;
            r_isLoad   <= 1'b0;
            r_pendErr  <= 1'b0;
            r_respDone <= 1'b0;
            r_rdData   <= 32'd0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= 32'd0;
            r_memWdata <= 32'd0;
            r_memBe    <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (w_accept) begin
                        r_funct3  <= funct3;
                        r_addrLo  <= addr[1:0];
                        r_isLoad  <= w_isLoad;
                        r_cnt     <= 8'd0;
                        r_pendErr <= 1'b0;
                        r_busy    <= 1'b1;
                        if (w_fault) begin
                            r_state    <= S_RESP;
                            r_respDone <= 1'b1;
                            r_done     <= 1'b1;
                            r_err      <= 1'b1;
                        end else begin
                            r_state    <= S_REQ;
                            r_respDone <= 1'b0;
                            r_memReq   <= 1'b1;
                            r_memWe    <= w_isStore;
                            r_memBe    <= w_be;
                            r_memAddr  <= {addr[31:2], 2'b00};
                            r_memWdata <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack || (w_cntNext == TIMEOUT)) begin
                        r_state    <= S_RESP;
                        r_respDone <= 1'b0;
                        r_memReq   <= 1'b0;
                        r_memWe    <= 1'b0;
                        r_memBe    <= 4'd0;
                        r_pendErr  <= !mem_ack;
                        if (mem_ack && r_isLoad) begin
                            r_rdData <= w_loadVal;
                        end
                    end else begin
                        r_cnt <= w_cntNext;
                    end
                end
                S_RESP: begin
                    if (!r_respDone) begin
                        r_respDone <= 1'b1;
                        r_done     <= 1'b1;
                        r_err      <= r_pendErr;
                    end else begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data   = r_rdData;
    assign done      = r_done;
    assign busy      = r_busy;
    assign err       = r_err;
    assign mem_req   = r_memReq;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_be    = r_memBe;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table of directed load/store vectors plus
// hand-written sequences for ignored starts and mid-transaction reset.
module tb_load_store_unit;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] NO_ACK   = 8'hFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic        done;
    logic        busy;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  ackDelay;
        int          expReqCycles;
        logic [31:0] expMemAddr;
        logic [3:0]  expBe;
        logic        expWe;
        logic [31:0] expMemWdata;
        logic [31:0] expRd;
        logic        expErr;
        int          expDoneCycle;
    } vec_t;

    vec_t vecs[$];

    load_store_unit #(.TIMEOUT(8'd4)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rd_data(rd_data), .done(done), .busy(busy),
        .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [6:0] op, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                                input logic [7:0] dly, input int reqc, input logic [31:0] ea,
                                input logic [3:0] ebe, input logic ewe, input logic [31:0] ewd,
                                input logic [31:0] erd, input logic eerr, input int edone);
        vec_t v;
        v.name = name; v.opcode = op; v.funct3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat;
        v.ackDelay = dly; v.expReqCycles = reqc; v.expMemAddr = ea; v.expBe = ebe; v.expWe = ewe;
        v.expMemWdata = ewd; v.expRd = erd; v.expErr = eerr; v.expDoneCycle = edone;
        return v;
    endfunction

    // Called at a negedge with the DUT idle; k counts negedges after the start cycle.
    task automatic applyStimulus(input vec_t v);
        int reqCycles;
        int doneCycle;
        reqCycles = 0;
        doneCycle = -1;
        start  = 1'b1;
        opcode = v.opcode;
        funct3 = v.funct3;
        addr   = v.addr;
        wdata  = v.wdata;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start   = 1'b0;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (reqCycles == 0) begin
                    checkOutput({v.name, " mem_addr"}, mem_addr, v.expMemAddr);
                    checkOutput({v.name, " mem_be"}, {28'd0, mem_be}, {28'd0, v.expBe});
                    checkOutput({v.name, " mem_we"}, {31'd0, mem_we}, {31'd0, v.expWe});
                    checkOutput({v.name, " mem_wdata"}, mem_wdata, v.expMemWdata);
                end
                if (v.ackDelay != NO_ACK && reqCycles == int'(v.ackDelay)) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
                reqCycles++;
            end
            if (done) begin
                doneCycle = k;
                checkOutput({v.name, " err"}, {31'd0, err}, {31'd0, v.expErr});
                checkOutput({v.name, " busy at done"}, {31'd0, busy}, 32'd1);
                break;
            end
        end
        mem_ack = 1'b0;
        checkOutput({v.name, " req cycles"}, reqCycles, v.expReqCycles);
        checkOutput({v.name, " done cycle"}, doneCycle, v.expDoneCycle);
        @(negedge clk);
        checkOutput({v.name, " rd_data"}, rd_data, v.expRd);
        checkOutput({v.name, " idle after"}, {29'd0, busy, done, err}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int seen;
        rst = 1'b1; start = 1'b0; opcode = 7'd0; funct3 = 3'd0; addr = 32'd0;
        wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;

        vecs.push_back(mk("SW",      OP_STORE, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 8'd0, 1, 32'h100, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 3));
        vecs.push_back(mk("LB",      OP_LOAD,  3'b000, 32'h103, 32'h0, 32'h80FF1234, 8'd0, 1, 32'h100, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 3));
        vecs.push_back(mk("LBU",     OP_LOAD,  3'b100, 32'h103, 32'h0, 32'h80FF1234, 8'd1, 2, 32'h100, 4'b1000, 1'b0, 32'h0, 32'h00000080, 1'b0, 4));
        vecs.push_back(mk("SH",      OP_STORE, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 8'd0, 1, 32'h200, 4'b1100, 1'b1, 32'hABCDABCD, 32'h00000080, 1'b0, 3));
        vecs.push_back(mk("LHU",     OP_LOAD,  3'b101, 32'h202, 32'h0, 32'hABCD0000, 8'd0, 1, 32'h200, 4'b1100, 1'b0, 32'h0, 32'h0000ABCD, 1'b0, 3));
        vecs.push_back(mk("LH",      OP_LOAD,  3'b001, 32'h200, 32'h0, 32'h12348001, 8'd0, 1, 32'h200, 4'b0011, 1'b0, 32'h0, 32'hFFFF8001, 1'b0, 3));
        vecs.push_back(mk("LW",      OP_LOAD,  3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 8'd2, 3, 32'h104, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 5));
        vecs.push_back(mk("SB",      OP_STORE, 3'b000, 32'h301, 32'h12345677, 32'h0, 8'd0, 1, 32'h300, 4'b0010, 1'b1, 32'h77777777, 32'hCAFEF00D, 1'b0, 3));
        vecs.push_back(mk("BADF3",   OP_LOAD,  3'b011, 32'h10, 32'h0, 32'h0, 8'd0, 0, 32'h0, 4'b0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b1, 1));
        vecs.push_back(mk("SBU",     OP_STORE, 3'b100, 32'h10, 32'h55, 32'h0, 8'd0, 0, 32'h0, 4'b0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b1, 1));
        vecs.push_back(mk("TIMEOUT", OP_LOAD,  3'b010, 32'h400, 32'h0, 32'h99999999, NO_ACK, 4, 32'h400, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D, 1'b1, 6));
        vecs.push_back(mk("LBU2",    OP_LOAD,  3'b100, 32'h102, 32'h0, 32'h11AA2233, 8'd0, 1, 32'h100, 4'b0100, 1'b0, 32'h0, 32'h000000AA, 1'b0, 3));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk("LWMIS",   OP_LOAD,  3'b010, 32'h101, 32'h0, 32'h11223344, 8'd0, 0, 32'h0, 4'b0, 1'b0, 32'h0, 32'h000000AA, 1'b1, 1));
`else
        vecs.push_back(mk("LWMIS",   OP_LOAD,  3'b010, 32'h101, 32'h0, 32'h11223344, 8'd0, 1, 32'h100, 4'b1111, 1'b0, 32'h0, 32'h11223344, 1'b0, 3));
`endif

        repeat (2) @(negedge clk);
        checkOutput("reset outputs", {22'd0, mem_req, mem_we, mem_be, done, err, busy, 1'b0},  32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'd0);
        checkOutput("reset rd_data", rd_data, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Non-memory opcode and a stray ack in IDLE must both be ignored.
        start = 1'b1; opcode = 7'b0110011; funct3 = 3'b010; addr = 32'h500; mem_ack = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_req || done || busy || err) seen++;
        end
        start = 1'b0; mem_ack = 1'b0;
        checkOutput("ignored start", seen, 0);

        // Reset during REQ drops mem_req immediately and suppresses done.
        start = 1'b1; opcode = OP_LOAD; funct3 = 3'b010; addr = 32'h600;
        @(negedge clk);
        start = 1'b0;
        checkOutput("pre-reset mem_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("post-reset req/busy", {30'd0, mem_req, busy}, 32'd0);
        checkOutput("post-reset rd_data", rd_data, 32'd0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            mem_ack = 1'b1;
            @(negedge clk);
            if (done || mem_req) seen++;
        end
        mem_ack = 1'b0;
        checkOutput("no done after reset", seen, 0);

        v = mk("SW2", OP_STORE, 3'b010, 32'h700, 32'h0BADF00D, 32'h0, 8'd0, 1, 32'h700, 4'b1111, 1'b1, 32'h0BADF00D, 32'h0, 1'b0, 3);
        applyStimulus(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT, 8'd255, max cycles waiting for mem_ack before aborting (1..255).
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  in  1  ALU result valid for current instruction.
REQ-005 SHALL have port: opcode  in  7  instruction opcode (LOAD 7'b0000011, STORE 7'b0100011).
REQ-006 SHALL have port: funct3  in  3  access size/sign.
REQ-007 SHALL have port: addr  in  32  effective address (ALU busC = rs1+imm).
REQ-008 SHALL have port: wdata  in  32  store data (rs2).
REQ-009 SHALL have port: rd_data  out  32  load result, extended to 32 bits.
REQ-010 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port: busy  out  1  pipeline stall request.
REQ-012 SHALL have port: err  out  1  access fault, valid with done.
REQ-013 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out 32 (addr with [1:0]=0), mem_wdata out 32, mem_be out 4, mem_rdata in 32, mem_ack in 1.

Function
REQ-014 SHALL implement FSM IDLE -> REQ -> RESP -> IDLE; busy=1 in REQ and RESP.
REQ-015 SHALL accept start only in IDLE with opcode LOAD/STORE; otherwise start ignored, no done.
REQ-016 SHALL register addr/funct3/wdata/opcode on acceptance (cycle N); mem_req=1 from cycle N+1, outputs stable until mem_ack sampled high.
REQ-017 SHALL deassert mem_req the cycle after mem_ack; done=1 exactly one cycle later (RESP); minimum latency start->done = 3 cycles with ack in first REQ cycle.
REQ-018 SHALL decode funct3: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; STORE uses only 000/001/010.
REQ-019 SHALL drive mem_be: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
REQ-020 SHALL replicate store data into lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-021 SHALL select load lane from mem_rdata by registered addr[1:0] and sign/zero extend per funct3; rd_data updated on ack, held until next load completes.
REQ-022 SHALL treat invalid funct3 (011,110,111; or 100/101 with STORE) as fault: no mem_req, err=1 with done 1 cycle after acceptance.
REQ-023 SHALL count REQ cycles; if count reaches TIMEOUT without ack, drop mem_req, go RESP, err=1, rd_data unchanged.
REQ-024 SHALL keep done=0, err=0 outside RESP; err cleared on next acceptance.
REQ-025 SHALL ignore mem_ack while in IDLE or RESP.

Reset
REQ-026 SHALL on rst=1 force state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rd_data=0, done=0, err=0, busy=0, timeout counter=0.
REQ-027 SHALL, on rst mid-transaction, drop mem_req at that edge and not emit done for the aborted access.

Configuration
REQ-028 SHALL with MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 raises fault per REQ-022 (no memory access).
REQ-029 SHALL without MISALIGN_TRAP_EN: no misalignment check; half ignores addr[0], word ignores addr[1:0].

Verification
REQ-030 SHALL test SW addr=0x100, wdata=0xDEADBEEF, ack in first REQ cycle -> mem_addr=0x100, be=1111, we=1, done at N+3, err=0.
REQ-031 SHALL test LB addr=0x103, mem_rdata=0x80FF_1234 -> rd_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SHALL test SH addr=0x202, wdata=0x0000ABCD -> be=1100, mem_wdata=0xABCDABCD; LHU addr=0x202, rdata=0xABCD0000 -> 0x0000ABCD.
REQ-033 SHALL test TIMEOUT=4, ack never -> mem_req 4 cycles, then done=1, err=1, busy falls after.
REQ-034 SHALL test LW addr=0x101: with MISALIGN_TRAP_EN err=1, mem_req never 1; without, mem_addr=0x100, normal completion.
REQ-035 SHALL test rst asserted during REQ -> mem_req=0 next cycle, no done; new start afterward completes normally.
